// File: rtl/debounce_pkg.sv
// debounce_pkg: shared width helper and default derived widths for the debouncer
package debounce_pkg;
  function automatic int ceillog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int PRESC_W = ceillog2(5000);
  localparam int STAB_W = ceillog2(4 + 1);
endpackage

// File: rtl/multi_channel_debouncer_if.sv
// multi_channel_debouncer_if: enable/din in, dout/rise/fall/tick out; master drives inputs, slave is the debouncer
interface multi_channel_debouncer_if #(parameter int CHANNELS = 4);
  logic enable;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] dout;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic tick;
  modport master(output enable, din, input dout, rise, fall, tick);
  modport slave(input enable, din, output dout, rise, fall, tick);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every CLK_DIV enabled cycles; ports clk, rst, enable in, tick out
module tick_prescaler
  import debounce_pkg::*;
#(
  parameter int CLK_DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int W = ceillog2(CLK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  logic tick_d, wrap;
  always_comb begin
    wrap = cnt_q == W'(CLK_DIV - 1);
    cnt_d = !enable ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    tick_d = enable && wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tick <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick <= tick_d;
    end
  end
endmodule

// File: rtl/multi_channel_debouncer.sv
// multi_channel_debouncer: N-channel debouncer; clk, rst plain, bus (slave) carries enable, din, dout, rise, fall, tick
module multi_channel_debouncer
  import debounce_pkg::*;
#(
  parameter int   CHANNELS       = 4,
  parameter int   CLK_DIV        = 5000,
  parameter int   STABLE_SAMPLES = 4,
  parameter logic RESET_LEVEL    = 1'b0
) (
  input logic clk,
  input logic rst,
  multi_channel_debouncer_if.slave bus
);
  localparam int SW = ceillog2(STABLE_SAMPLES + 1);
  logic tick;
  logic [CHANNELS-1:0] dout_w, rise_w, fall_w;
  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk(clk),
    .rst(rst),
    .enable(bus.enable),
    .tick(tick)
  );
  assign bus.tick = tick;
  assign bus.dout = dout_w;
  assign bus.rise = rise_w;
  assign bus.fall = fall_w;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0] sync_q;
    logic [SW-1:0] stab_q, stab_d;
    logic dout_q, dout_d, rise_q, rise_d, fall_q, fall_d, diff, done;
    always_comb begin
      diff = sync_q[1] != dout_q;
      done = tick && diff && (stab_q + 1'b1 == SW'(STABLE_SAMPLES));
      // a sample that agrees with dout discards any partial progress
      stab_d = !tick ? stab_q : (!diff || done) ? '0 : stab_q + 1'b1;
      dout_d = done ? sync_q[1] : dout_q;
      rise_d = done && sync_q[1];
      fall_d = done && !sync_q[1];
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= {2{RESET_LEVEL}};
        stab_q <= '0;
        dout_q <= RESET_LEVEL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], bus.din[c]};
        stab_q <= stab_d;
        dout_q <= dout_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end
    assign dout_w[c] = dout_q;
    assign rise_w[c] = rise_q;
    assign fall_w[c] = fall_q;
  end
endmodule

// File: tb/tb_multi_channel_debouncer.sv
// tb_multi_channel_debouncer: table, directed and randomized checks against a behavioural model
module tb_multi_channel_debouncer;
  localparam int CH = 4;
  localparam int D = 4;
  localparam int S = 3;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  multi_channel_debouncer_if #(.CHANNELS(CH)) bus ();
  multi_channel_debouncer #(
    .CHANNELS(CH),
    .CLK_DIV(D),
    .STABLE_SAMPLES(S),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Behavioural model: tick from the count of enabled cycles since reset,
  // sync as a two-deep input history, per channel a run length of disagreeing samples.
  int en_edges;
  bit m_tick, model_ok = 0;
  bit [CH-1:0] s1, s2, m_dout, m_rise, m_fall;
  int m_run [CH];
  always @(posedge clk) begin
    bit [CH-1:0] nd, nr, nf;
    int nrun [CH];
    int ne;
    if (rst) begin
      en_edges <= 0;
      m_tick <= 0;
      s1 <= 0;
      s2 <= 0;
      m_dout <= 0;
      m_rise <= 0;
      m_fall <= 0;
      m_run <= '{default: 0};
      model_ok <= 1;
    end else begin
      nd = m_dout;
      nr = 0;
      nf = 0;
      nrun = m_run;
      if (m_tick)
        for (int c = 0; c < CH; c++) begin
          if (s2[c] != m_dout[c]) begin
            nrun[c] = m_run[c] + 1;
            if (nrun[c] == S) begin
              nd[c] = s2[c];
              nrun[c] = 0;
              nr[c] = s2[c];
              nf[c] = !s2[c];
            end
          end else nrun[c] = 0;
        end
      ne = en_edges + (bus.enable ? 1 : 0);
      en_edges <= ne;
      m_tick <= bus.enable && (ne % D == 0);
      m_dout <= nd;
      m_rise <= nr;
      m_fall <= nf;
      m_run <= nrun;
      s2 <= s1;
      s1 <= bus.din;
    end
  end
  always @(negedge clk)
    if (model_ok) begin
      chk("model_dout", 32'(bus.dout), 32'(m_dout));
      chk("model_rise", 32'(bus.rise), 32'(m_rise));
      chk("model_fall", 32'(bus.fall), 32'(m_fall));
      chk("model_tick", 32'(bus.tick), 32'(m_tick));
      chk("rise_fall_excl", 32'(bus.rise & bus.fall), 0);
    end
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  typedef struct {
    logic rst;
    logic [CH-1:0] din;
    logic tick;
    logic [CH-1:0] dout;
  } vec_t;
  vec_t vecs [15];
  initial begin
    int n;
    bit seen;
    logic [CH-1:0] d0;
    for (int i = 0; i < 15; i++) begin
      vecs[i].rst = i < 3;
      vecs[i].din = i < 3 ? 4'hF : 4'h0;
      vecs[i].tick = i >= 3 && ((i - 2) % D == 0);
      vecs[i].dout = 4'h0;
    end
    bus.enable = 1'b1;
    bus.din = 4'hF;
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst;
      bus.din = vecs[i].din;
      step();
      chk($sformatf("vec%0d_tick", i), 32'(bus.tick), 32'(vecs[i].tick));
      chk($sformatf("vec%0d_dout", i), 32'(bus.dout), 32'(vecs[i].dout));
      chk($sformatf("vec%0d_pulse", i), 32'(bus.rise | bus.fall), 0);
    end
    // clean press on channel 0
    bus.din = 4'b0001;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.dout[0] && n < 40);
    chk("press_latency_ok", 32'(n >= 2 + (S - 1) * D + 1 && n <= 2 + S * D + 1), 1);
    chk("press_rise", 32'(bus.rise), 4'b0001);
    chk("press_dout", 32'(bus.dout), 4'b0001);
    step();
    chk("press_rise_one_cycle", 32'(bus.rise), 0);
    // bounce on channel 1: too short to be accepted
    bus.din = 4'b0011;
    seen = 0;
    repeat (6) begin
      step();
      seen |= bus.dout[1] | bus.rise[1] | bus.fall[1];
    end
    bus.din = 4'b0001;
    repeat (30) begin
      step();
      seen |= bus.dout[1] | bus.rise[1] | bus.fall[1];
    end
    chk("bounce_reject", 32'(seen), 0);
    // simultaneous release and press
    bus.din = 4'b1110;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.dout == 4'b0001 && n < 40);
    chk("simul_dout", 32'(bus.dout), 4'b1110);
    chk("simul_rise", 32'(bus.rise), 4'b1110);
    chk("simul_fall", 32'(bus.fall), 4'b0001);
    step();
    chk("simul_pulse_end", 32'({bus.rise, bus.fall}), 0);
    // enable hold after two agreeing samples
    bus.din = 4'b0000;
    n = 0;
    while (m_run[1] != 2 && n < 40) begin
      step();
      n++;
    end
    chk("hold_reach_two", 32'(m_run[1]), 2);
    bus.enable = 1'b0;
    d0 = bus.dout;
    seen = 0;
    repeat (20) begin
      step();
      seen |= bus.tick | (bus.dout != d0);
    end
    chk("hold_frozen", 32'(seen), 0);
    bus.enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.dout == d0 && n < 40);
    chk("hold_resume_latency", 32'(n), D);
    chk("hold_resume_dout", 32'(bus.dout), 4'b0000);
    // reset after two agreeing samples discards progress
    bus.din = 4'b1111;
    n = 0;
    while (m_run[0] != 2 && n < 40) begin
      step();
      n++;
    end
    chk("rstmid_reach_two", 32'(m_run[0]), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_dout", 32'(bus.dout), 0);
    chk("rstmid_pulses_tick", 32'({bus.rise, bus.fall, bus.tick}), 0);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.dout != 4'hF && n < 40);
    chk("rstmid_full_latency", 32'(n), 1 + S * D);
    // randomized stimulus, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 15) == 0) bus.din[c] = !bus.din[c];
      bus.enable = $urandom_range(0, 9) != 0;
      rst = $urandom_range(0, 499) == 0;
      step();
    end
    rst = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_channel_debouncer.md
# multi_channel_debouncer

Parametrised N-channel debouncer for push-buttons and slow mechanical inputs. An internal prescaler generates a shared sample strobe. Each channel accepts a new level only after STABLE_SAMPLES consecutive strobes agree on it. Per channel it outputs the debounced level plus one-cycle rise/fall pulses. It sits between the board pins and the control logic, replacing single-channel counter-based debouncing in the frequency-meter and later designs.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- CLK_DIV, 5000, clk cycles per sample strobe (≥2)
- STABLE_SAMPLES, 4, consecutive agreeing samples needed to accept a new level (≥1)
- RESET_LEVEL, 0, 1-bit reset value of synchronisers and debounced outputs, same for all channels

- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- enable  in  1  1 = prescaler runs; 0 = prescaler and all channel counters hold
- din  in  CHANNELS  raw asynchronous inputs
- dout  out  CHANNELS  debounced levels
- rise  out  CHANNELS  one-cycle pulse on accepted 0→1
- fall  out  CHANNELS  one-cycle pulse on accepted 1→0
- tick  out  1  sample strobe, one cycle wide

## Operation
- Reset values: dout = {CHANNELS{RESET_LEVEL}}; rise = fall = 0; tick = 0; prescaler count = 0; stability counters = 0; synchroniser flops = RESET_LEVEL.
- Synchroniser: 2 flops per channel; sync[i] is din[i] delayed 2 cycles.
- Prescaler, on each edge with enable = 1:
  - count == CLK_DIV-1: count ← 0, tick ← 1.
  - otherwise: count ← count+1, tick ← 0.
- Prescaler with enable = 0: count holds, tick ← 0.
- Prescaler count width is ceillog2(CLK_DIV), minimum 1.
- Per channel, evaluated on the edge that ends a tick-high cycle:
  - sync ≠ dout and stab+1 == STABLE_SAMPLES: dout ← sync; stab ← 0; rise or fall ← 1 according to the new level.
  - sync ≠ dout, otherwise: stab ← stab+1.
  - sync == dout: stab ← 0. A bounce resets progress.
- On every other edge: stab and dout hold; rise, fall ← 0.
- Stability counter width is ceillog2(STABLE_SAMPLES+1).
- Channels are fully independent. Any subset may change in the same cycle.
- STABLE_SAMPLES = 1: dout follows sync at the first tick on which they differ.
- rise and fall are never both high on one channel.

## Timing
- First tick after rst deasserts: high during the cycle after the CLK_DIV-th enabled edge. Thereafter its period is exactly CLK_DIV enabled cycles.
- dout and the matching rise/fall pulse change on the same edge. The pulse lasts exactly one cycle.
- Step on din, held stable: dout changes on the STABLE_SAMPLES-th tick evaluation after sync changes. Latency from din is between 2+(STABLE_SAMPLES-1)·CLK_DIV+1 and 2+STABLE_SAMPLES·CLK_DIV+1 cycles (enable = 1).
- enable dropped mid-count: no ticks are generated, all state holds, and no samples are lost or counted. Counting resumes where it stopped.
- rst mid-operation: all outputs and state return to reset values on the next edge. Partial counts are discarded. rst has priority over enable and tick.

## Structure
- Package debounce_pkg holds the ceillog2 constant function (integer in, integer out, result ≥1) and the derived widths PRESC_W and STAB_W.
- Sub-module tick_prescaler (parameter CLK_DIV; ports clk, rst, enable, tick) is the generalised successor of the free-running strobe counter. It is instantiated once and shared by all channels.
- Per-channel synchroniser and stability logic are written as a generate loop, not as a sub-module.

## Test plan
Bench uses CHANNELS=4, CLK_DIV=4, STABLE_SAMPLES=3, RESET_LEVEL=0.
- Reset check: rst high for 3 cycles with din=4'hF → dout=0, rise=fall=0, tick=0. After release, tick is first high in cycle 5 and every 4 cycles thereafter.
- Clean press: din[0] 0→1 and held → dout[0]=1 at the 3rd tick evaluation seeing sync[0]=1; rise[0]=1 for exactly one cycle; dout[3:1] and other pulses stay 0.
- Bounce reject: din[1] high for 6 cycles (≤2 tick samples), then low → dout[1] stays 0; no rise/fall.
- Release and simultaneous change: din goes 4'b0001→4'b1110 in one cycle → dout=4'b1110 on a single edge; rise=4'b1110 and fall=4'b0001 for one cycle.
- Enable hold: enable=0 for 20 cycles after 2 agreeing samples → no ticks and dout unchanged. After enable=1, dout changes at the next tick evaluation.
- Reset mid-count: rst pulsed one cycle after 2 agreeing samples → dout=0 and stab=0 next cycle. The full 3 samples are then required again.
